// File: rtl/msk_round_ctrl.sv
// Round sequencer for a masked block-cipher datapath: loads input shares, steps
// NROUNDS rounds through a LAT-cycle masked pipeline gated by fresh randomness.
module msk_round_ctrl #(
    parameter int NROUNDS = 10,
    parameter int LAT     = 4,
    localparam int RW     = (NROUNDS > 1) ? $clog2(NROUNDS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          ready,
    input  logic          clear,
    input  logic          rnd_valid,
    output logic          rnd_req,
    output logic          en_load,
    output logic          en_round,
    output logic          pipe_en,
    output logic [RW-1:0] round_idx,
    output logic          last_round,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [RW-1:0] ROUND_MAX = RW'(NROUNDS - 1);
    localparam logic [LW-1:0] LAT_MAX   = LW'(LAT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [LW-1:0] lat_cnt;
    logic          is_last;
    logic          step;

    // The pipeline only advances on cycles that also consume a fresh mask.
    assign is_last    = (round_idx == ROUND_MAX);
    assign step       = (state == S_CALC) && rnd_valid && !clear;

    assign ready      = (state == S_IDLE);
    assign en_load    = (state == S_LOAD) && !clear;
    assign rnd_req    = step;
    assign pipe_en    = step;
    assign en_round   = step && (lat_cnt == LAT_MAX);
    assign last_round = (state == S_CALC) && is_last;
    assign out_valid  = (state == S_DONE) && !clear;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_CALC;
            S_CALC:  if (en_round && is_last) state_nx = S_DONE;
            S_DONE:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (clear) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // round_idx stays at the final round through DONE so the result can be tagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt   <= '0;
            round_idx <= '0;
        end else if (clear || (state == S_LOAD)) begin
            lat_cnt   <= '0;
            round_idx <= '0;
        end else if (step) begin
            if (lat_cnt == LAT_MAX) begin
                lat_cnt <= '0;
                if (!is_last) round_idx <= round_idx + 1'b1;
            end else begin
                lat_cnt <= lat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_msk_round_ctrl.sv
// Scoreboard bench for msk_round_ctrl: a cycle-schedule model predicts the
// load/round/done events and a negedge monitor matches what the DUT produces.
module tb_msk_round_ctrl;

    localparam int NR     = 3;
    localparam int LT     = 2;
    localparam int MAXL   = 512;
    localparam int K_LOAD = 0;
    localparam int K_ROUND = 1;
    localparam int K_BEGIN = 2;
    localparam int K_ACK   = 3;

    typedef struct {
        int kind;
        int cyc;
        int idx;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, clear = 1'b0, rnd_valid = 1'b0, out_ready = 1'b0;
    logic       ready, rnd_req, en_load, en_round, pipe_en, last_round, out_valid;
    logic [1:0] round_idx;

    logic       start1 = 1'b0, clear1 = 1'b0, rnd_valid1 = 1'b0, out_ready1 = 1'b0;
    logic       ready1, rnd_req1, en_load1, en_round1, pipe_en1, last_round1, out_valid1;
    logic [0:0] round_idx1;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   base = 0;
    int   seq_len = 0;
    bit   seq_active = 1'b0;
    bit   ev_mon_en = 1'b1;
    logic ov_prev = 1'b0;

    bit   st_a[MAXL], rv_a[MAXL], or_a[MAXL], cl_a[MAXL];
    bit   ex_ready[MAXL], ex_calc[MAXL];
    ev_t  sb[$];
    int   seen_round[$];
    int   seen_begin[$];

    msk_round_ctrl #(.NROUNDS(NR), .LAT(LT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .clear(clear),
        .rnd_valid(rnd_valid), .rnd_req(rnd_req), .en_load(en_load),
        .en_round(en_round), .pipe_en(pipe_en), .round_idx(round_idx),
        .last_round(last_round), .out_valid(out_valid), .out_ready(out_ready)
    );

    msk_round_ctrl #(.NROUNDS(1), .LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .ready(ready1), .clear(clear1),
        .rnd_valid(rnd_valid1), .rnd_req(rnd_req1), .en_load(en_load1),
        .en_round(en_round1), .pipe_en(pipe_en1), .round_idx(round_idx1),
        .last_round(last_round1), .out_valid(out_valid1), .out_ready(out_ready1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic void pushEv(input int kind, input int c, input int idx);
        ev_t e;
        e.kind = kind;
        e.cyc  = base + c;
        e.idx  = idx;
        sb.push_back(e);
    endfunction

    // Walk the input schedule: idle until an accepted start, one load cycle,
    // then NR*LT randomness-carrying cycles, then wait for out_ready; clear aborts.
    function automatic void planSchedule(input int len);
        int t, s, c, cnt, done_c;
        sb.delete();
        for (int i = 0; i < MAXL; i++) begin
            ex_ready[i] = 1'b0;
            ex_calc[i]  = 1'b0;
        end
        t = 0;
        while (t < len) begin
            s = t;
            while (s < len && !(st_a[s] && !cl_a[s])) begin
                ex_ready[s] = 1'b1;
                s++;
            end
            if (s >= len) break;
            ex_ready[s] = 1'b1;
            c = s + 1;
            if (c >= len) break;
            if (cl_a[c]) begin
                t = c + 1;
                continue;
            end
            pushEv(K_LOAD, c, 0);
            cnt = 0;
            done_c = -1;
            for (c = s + 2; c < len; c++) begin
                if (cl_a[c]) break;
                ex_calc[c] = 1'b1;
                if (rv_a[c]) begin
                    cnt++;
                    if (cnt % LT == 0) pushEv(K_ROUND, c, cnt / LT - 1);
                    if (cnt == NR * LT) begin
                        done_c = c + 1;
                        break;
                    end
                end
            end
            if (done_c < 0) begin
                t = c + 1;
                continue;
            end
            for (c = done_c; c < len; c++) begin
                if (cl_a[c]) break;
                if (c == done_c) pushEv(K_BEGIN, c, 0);
                if (or_a[c]) begin
                    pushEv(K_ACK, c, 0);
                    break;
                end
            end
            t = c + 1;
        end
    endfunction

    task automatic popCheck(input int kind, input logic [31:0] idx, input logic lr);
        ev_t e;
        if (sb.size() == 0) begin
            checkOutput("unexpected_event_kind", kind, 32'hFFFF_FFFF);
            return;
        end
        e = sb.pop_front();
        checkOutput("event_kind", kind, e.kind);
        checkOutput("event_cycle", cyc, e.cyc);
        if (kind == K_ROUND) begin
            checkOutput("round_idx_at_en_round", idx, e.idx);
            checkOutput("last_round_at_en_round", lr, (e.idx == NR - 1));
        end
    endtask

    // Monitor: events are matched against the scoreboard as the DUT raises them.
    always @(negedge clk) begin
        if (rst_n && ev_mon_en) begin
            if (en_load) popCheck(K_LOAD, 0, 1'b0);
            if (en_round) begin
                popCheck(K_ROUND, round_idx, last_round);
                seen_round.push_back(cyc - base);
            end
            if (out_valid && !ov_prev) begin
                popCheck(K_BEGIN, 0, 1'b0);
                checkOutput("round_idx_in_done", round_idx, NR - 1);
                seen_begin.push_back(cyc - base);
            end
            if (out_valid && out_ready) popCheck(K_ACK, 0, 1'b0);
            checkOutput("load_round_exclusive", en_load && en_round, 0);
        end
        if (seq_active && (cyc - base) < seq_len) begin
            checkOutput("ready", ready, ex_ready[cyc - base]);
            checkOutput("rnd_req", rnd_req, ex_calc[cyc - base] && rv_a[cyc - base]);
            checkOutput("pipe_en", pipe_en, ex_calc[cyc - base] && rv_a[cyc - base]);
        end
        ov_prev = out_valid;
    end

    function automatic void defaultArrays();
        for (int i = 0; i < MAXL; i++) begin
            st_a[i] = 1'b0;
            rv_a[i] = 1'b1;
            or_a[i] = 1'b1;
            cl_a[i] = 1'b0;
        end
    endfunction

    function automatic void randomArrays(input int rand_len);
        defaultArrays();
        for (int i = 0; i < rand_len; i++) begin
            st_a[i] = ($urandom_range(3) == 0);
            rv_a[i] = ($urandom_range(3) != 0);
            or_a[i] = $urandom_range(1);
            cl_a[i] = ($urandom_range(39) == 0);
        end
    endfunction

    task automatic applyStimulus(input int len);
        @(posedge clk); #1;
        base    = cyc;
        seq_len = len;
        planSchedule(len);
        seen_round.delete();
        seen_begin.delete();
        seq_active = 1'b1;
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            start     = st_a[i];
            rnd_valid = rv_a[i];
            out_ready = or_a[i];
            clear     = cl_a[i];
        end
        @(posedge clk); #1;
        seq_active = 1'b0;
        start = 1'b0; clear = 1'b0; rnd_valid = 1'b0; out_ready = 1'b0;
        checkOutput("scoreboard_drained", sb.size(), 0);
    endtask

    // Hand-written cycle numbers, independent of the schedule model.
    task automatic checkSeen(input string tag, input int n, input int r0, input int r1,
                             input int r2, input int r3, input int b);
        int exp_r[4];
        exp_r = '{r0, r1, r2, r3};
        checkOutput({tag, "_round_count"}, seen_round.size(), n);
        if (seen_round.size() == n) begin
            for (int i = 0; i < n; i++) checkOutput({tag, "_round_cycle"}, seen_round[i], exp_r[i]);
        end
        checkOutput({tag, "_first_out_valid"}, (seen_begin.size() > 0) ? seen_begin[0] : -1, b);
    endtask

    task automatic resetTest();
        ev_mon_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("pre_reset_in_calc", pipe_en, 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ready", ready, 1);
        checkOutput("async_rst_round_idx", round_idx, 0);
        checkOutput("async_rst_en_load", en_load, 0);
        checkOutput("async_rst_en_round", en_round, 0);
        checkOutput("async_rst_pipe_en", pipe_en, 0);
        checkOutput("async_rst_rnd_req", rnd_req, 0);
        checkOutput("async_rst_last_round", last_round, 0);
        checkOutput("async_rst_out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("post_rst_no_pulse", {en_load, en_round, pipe_en, out_valid}, 0);
            checkOutput("post_rst_ready", ready, 1);
        end
        rnd_valid = 1'b0; out_ready = 1'b0;
        ov_prev = out_valid;
        ev_mon_en = 1'b1;
    endtask

    task automatic singleRoundTest();
        @(posedge clk); #1;
        start1 = 1'b1; rnd_valid1 = 1'b1; out_ready1 = 1'b1;
        for (int r = 0; r < 6; r++) begin
            if (r > 0) begin
                @(posedge clk); #1;
                start1 = 1'b0;
            end
            @(negedge clk);
            checkOutput("nr1_en_load", en_load1, (r == 1));
            checkOutput("nr1_en_round", en_round1, (r == 2));
            checkOutput("nr1_last_round", last_round1, (r == 2));
            checkOutput("nr1_out_valid", out_valid1, (r == 3));
            checkOutput("nr1_ready", ready1, (r == 0 || r >= 4));
        end
        start1 = 1'b0; rnd_valid1 = 1'b0; out_ready1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_ready", ready, 1);
        checkOutput("reset_round_idx", round_idx, 0);
        checkOutput("reset_enables", {en_load, en_round, pipe_en, rnd_req}, 0);
        checkOutput("reset_last_round", last_round, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_ready_nr1", ready1, 1);
        @(negedge clk);
        rst_n = 1'b1;

        defaultArrays();
        st_a[0] = 1'b1;
        applyStimulus(16);
        checkSeen("basic", 3, 3, 5, 7, 0, 8);

        defaultArrays();
        st_a[0] = 1'b1;
        rv_a[4] = 1'b0;
        rv_a[5] = 1'b0;
        applyStimulus(16);
        checkSeen("stall", 3, 3, 7, 9, 0, 10);

        defaultArrays();
        st_a[0] = 1'b1;
        or_a[8] = 1'b0; or_a[9] = 1'b0; or_a[10] = 1'b0;
        applyStimulus(16);
        checkSeen("backpressure", 3, 3, 5, 7, 0, 8);

        defaultArrays();
        st_a[0] = 1'b1;
        st_a[3] = 1'b1; st_a[4] = 1'b1; st_a[6] = 1'b1;
        applyStimulus(16);
        checkSeen("start_in_calc", 3, 3, 5, 7, 0, 8);

        defaultArrays();
        st_a[0] = 1'b1;
        cl_a[4] = 1'b1;
        st_a[6] = 1'b1;
        applyStimulus(20);
        checkSeen("clear", 4, 3, 9, 11, 13, 14);

        for (int k = 0; k < 2; k++) begin
            randomArrays(350);
            applyStimulus(500);
        end

        resetTest();

        defaultArrays();
        st_a[0] = 1'b1;
        applyStimulus(16);
        checkSeen("after_reset", 3, 3, 5, 7, 0, 8);

        singleRoundTest();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
